sync_fifo_cfg: RTL

Parametrised single-clock FIFO, next generation of the team's synchronous FIFO: selectable standard or first-word-fall-through (FWFT) read mode, run-time programmable almost-full/almost-empty thresholds, an occupancy output, and sticky overflow/underflow error flags. It sits between a producer and a consumer in one clock domain and provides the registered-read RAM storage plus all flag and handshake logic.

---
 rtl/sync_fifo_cfg.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_cfg.sv
// sync_fifo_cfg: single-clock FIFO with standard or first-word-fall-through
// read, live almost-full/almost-empty thresholds, occupancy output and
// sticky overflow/underflow flags. Storage is an inferred RAM with a
// registered read port.
module sync_fifo_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int                DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    // Storage; contents are deliberately left unreset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic full_w;
    logic empty_w;
    logic wr_accept;
    logic rd_accept;

    // Status flags decode straight from the count register.
    assign full_w       = (count_q == DEPTH_CNT);
    assign empty_w      = (count_q == '0);
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign rd_data      = rd_data_q;

    // A request is only honoured when it cannot corrupt occupancy.
    assign wr_accept = wr_en && !full_w;
    assign rd_accept = rd_en && !empty_w;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Sticky error flags; a fresh error in the clearing cycle takes priority.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full_w) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty_w) begin
            underflow_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Registered read port shared by both read modes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic rd_valid_q;
            logic rd_valid_d;

            // Standard mode: load the output only on an accepted read and
            // pulse rd_valid for the cycle the new word is visible.
            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = rd_accept;
                if (rd_accept) begin
                    rd_data_d = mem[rd_ptr_q];
                end
            end

            // One-cycle data-valid pulse register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_valid = rd_valid_q;
        end else begin : g_fwft
            // FWFT mode: the RAM is read every cycle at the head address the
            // pointer will hold after this edge, so a pop exposes the next
            // word with no bubble. When the word being written lands in that
            // head slot (empty FIFO, or single word popped while writing),
            // the RAM read would return stale data, so the write is bypassed.
            always_comb begin
                rd_data_d = mem[rd_ptr_d];
                if (wr_accept && (wr_ptr_q == rd_ptr_d)) begin
                    rd_data_d = wr_data;
                end
            end

            assign rd_valid = !empty_w;
        end
    endgenerate

endmodule
